fingerprint_sequencer: RTL and testbench

Control FSM that runs the acoustic-fingerprint flow without manual switches: it captures a reference sample into storage bank 1, then a probe sample into bank 2, then triggers the comparator and latches the verdict. It sits between the user buttons and the two audio sample storage instances plus the comparator, and drives their enable inputs in place of the three slide switches. It also guards every phase with a timeout so a stuck bank or comparator reports an error instead of hanging.

---
 rtl/fp_pkg.sv | 37 +++
 rtl/seq_phase_counter.sv | 40 ++++
 rtl/fingerprint_sequencer.sv | 150 +++++++++++++++
 tb/tb_fingerprint_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg
//   Shared definitions for the acoustic-fingerprint flow: the sequencer state
//   encoding (exported on state_o for LEDs), default sizing constants used by
//   the sample storage and comparator blocks, and the phase counter width.
package fp_pkg;

  // Fixed encodings; the LED/debug display relies on these exact values.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAP1    = 3'd1,
    ST_CLR     = 3'd2,
    ST_CAP2    = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERROR   = 3'd6
  } seq_state_e;

  localparam int NUM_SAMPLES  = 50;
  localparam int SAMPLE_WIDTH = 20;

  // Wide enough for the compare timeout plus headroom.
  localparam int CNT_WIDTH = 16;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

  // Clamp an integer limit into the counter range so an oversized parameter
  // saturates instead of silently truncating to a small value.
  function automatic logic [CNT_WIDTH-1:0] to_count(input int value);
    if (value > CNT_MAX) begin
      return CNT_WIDTH'(CNT_MAX);
    end
    if (value < 1) begin
      return CNT_WIDTH'(1);
    end
    return CNT_WIDTH'(value);
  endfunction

endpackage

// File: rtl/seq_phase_counter.sv
// seq_phase_counter
//   Saturating phase counter shared by all timed phases of the sequencer.
//   Ports:
//     clock, reset_BTN : clock, asynchronous active-low reset
//     clr              : synchronous clear (wins over inc)
//     inc              : increment strobe (sample tick or constant 1)
//     limit            : terminal count for the current phase
//     hit              : combinational; 1 when this increment reaches limit
module seq_phase_counter
  import fp_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_BTN,
  input  logic                 clr,
  input  logic                 inc,
  input  logic [CNT_WIDTH-1:0] limit,
  output logic                 hit
);

  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] count_plus;

  // Holds at all-ones instead of wrapping back to zero.
  assign count_plus = (count == '1) ? count : count + 1'b1;

  // Looks ahead one increment so the owner can leave the phase in the same
  // cycle as the limit-th event rather than one cycle later.
  assign hit = inc && (count_plus >= limit);

  always_ff @(posedge clock or negedge reset_BTN) begin
    if (!reset_BTN) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count_plus;
    end
  end

endmodule

// File: rtl/fingerprint_sequencer.sv
// fingerprint_sequencer
//   Control FSM for the fingerprint flow: captures a reference into bank 1,
//   a probe into bank 2, runs the comparator and latches the verdict. Each
//   timed phase is guarded by a timeout that lands in ERROR.
//   Inputs : clock, reset_BTN (async active-low), start (rising edge runs),
//            abort (level, forces IDLE), sample_tick, stored1_done,
//            stored2_done, cmp_valid, cmp_match
//   Outputs: cap1_en, cap2_en, cmp_en, busy, result_valid, match, error,
//            state_o[2:0] (fp_pkg encoding); all registered
//   Build option: SEQ_AUTO_REARM_EN makes DONE loop back through CLR to
//   recapture bank 2 and compare again; without it DONE waits for start.
module fingerprint_sequencer
  import fp_pkg::*;
#(
  parameter int NUM_SAMPLES = fp_pkg::NUM_SAMPLES,
  parameter int TICK_MARGIN = 8,
  parameter int CMP_TIMEOUT = 4096
) (
  input  logic       clock,
  input  logic       reset_BTN,
  input  logic       start,
  input  logic       abort,
  input  logic       sample_tick,
  input  logic       stored1_done,
  input  logic       stored2_done,
  input  logic       cmp_valid,
  input  logic       cmp_match,
  output logic       cap1_en,
  output logic       cap2_en,
  output logic       cmp_en,
  output logic       busy,
  output logic       result_valid,
  output logic       match,
  output logic       error,
  output logic [2:0] state_o
);

  localparam logic [CNT_WIDTH-1:0] CAP_LIMIT = to_count(NUM_SAMPLES + TICK_MARGIN);
  localparam logic [CNT_WIDTH-1:0] CMP_LIMIT = to_count(CMP_TIMEOUT);

  seq_state_e           state;
  seq_state_e           next_state;
  logic                 start_q;
  logic                 start_rise;
  logic                 cnt_clr;
  logic                 cnt_inc;
  logic                 cnt_hit;
  logic [CNT_WIDTH-1:0] phase_limit;
  logic                 match_next;

  assign start_rise = start & ~start_q;
  assign state_o    = state;

  seq_phase_counter u_counter (
    .clock     (clock),
    .reset_BTN (reset_BTN),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
    .limit     (phase_limit),
    .hit       (cnt_hit)
  );

  // Next-state logic. Done/valid inputs only matter in their own phase, and
  // a done arriving together with the final tick wins over the timeout.
  always_comb begin
    next_state  = state;
    cnt_inc     = 1'b0;
    phase_limit = CAP_LIMIT;
    match_next  = match;

    unique case (state)
      ST_IDLE: begin
        if (start_rise) next_state = ST_CAP1;
      end
      ST_CAP1: begin
        cnt_inc = sample_tick;
        if (stored1_done)  next_state = ST_CLR;
        else if (cnt_hit)  next_state = ST_ERROR;
      end
      ST_CLR: begin
        next_state = ST_CAP2;
      end
      ST_CAP2: begin
        cnt_inc = sample_tick;
        if (stored2_done)  next_state = ST_COMPARE;
        else if (cnt_hit)  next_state = ST_ERROR;
      end
      ST_COMPARE: begin
        cnt_inc     = 1'b1;
        phase_limit = CMP_LIMIT;
        if (cmp_valid) begin
          next_state = ST_DONE;
          match_next = cmp_match;
        end else if (cnt_hit) begin
          next_state = ST_ERROR;
        end
      end
      ST_DONE: begin
`ifdef SEQ_AUTO_REARM_EN
        if (start_rise) next_state = ST_CAP1;
        else            next_state = ST_CLR;
`else
        if (start_rise) next_state = ST_CAP1;
`endif
      end
      ST_ERROR: begin
        if (start_rise) next_state = ST_CAP1;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase

    if (abort) next_state = ST_IDLE;

    // A fresh run or an abort discards the previous verdict.
    if (next_state == ST_IDLE || next_state == ST_CAP1) match_next = 1'b0;

    // Every phase change restarts the counter from zero.
    cnt_clr = (next_state != state);
  end

  // State and outputs are registered from the next state so every output
  // changes in the cycle after its triggering condition. The start history
  // resets to 1 so a start held through reset is not seen as an edge.
  always_ff @(posedge clock or negedge reset_BTN) begin
    if (!reset_BTN) begin
      state        <= ST_IDLE;
      start_q      <= 1'b1;
      cap1_en      <= 1'b0;
      cap2_en      <= 1'b0;
      cmp_en       <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      match        <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= next_state;
      start_q      <= start;
      cap1_en      <= (next_state == ST_CAP1);
      cap2_en      <= (next_state == ST_CAP2);
      cmp_en       <= (next_state == ST_COMPARE);
      busy         <= next_state inside {ST_CAP1, ST_CLR, ST_CAP2, ST_COMPARE};
      result_valid <= (next_state == ST_DONE);
      match        <= match_next;
      error        <= (next_state == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_fingerprint_sequencer.sv
// tb_fingerprint_sequencer
//   Randomized scoreboard bench. Stimulus tasks derive, from the phase rules
//   and cycle timing of the flow, when each output change must appear and
//   queue it; a monitor pops an entry whenever the DUT outputs change and
//   compares both the cycle and the full output vector.
module tb_fingerprint_sequencer;
  import fp_pkg::*;

  localparam int NS        = 50;
  localparam int TM        = 8;
  localparam int CT        = 4096;
  localparam int CAP_LIMIT = NS + TM;

  logic       clock = 1'b0;
  logic       reset_BTN;
  logic       start, abort, sample_tick;
  logic       stored1_done, stored2_done, cmp_valid, cmp_match;
  logic       cap1_en, cap2_en, cmp_en, busy, result_valid, match, error;
  logic [2:0] state_o;
  logic [9:0] outs;

  fingerprint_sequencer #(
    .NUM_SAMPLES (NS),
    .TICK_MARGIN (TM),
    .CMP_TIMEOUT (CT)
  ) dut (
    .clock        (clock),
    .reset_BTN    (reset_BTN),
    .start        (start),
    .abort        (abort),
    .sample_tick  (sample_tick),
    .stored1_done (stored1_done),
    .stored2_done (stored2_done),
    .cmp_valid    (cmp_valid),
    .cmp_match    (cmp_match),
    .cap1_en      (cap1_en),
    .cap2_en      (cap2_en),
    .cmp_en       (cmp_en),
    .busy         (busy),
    .result_valid (result_valid),
    .match        (match),
    .error        (error),
    .state_o      (state_o)
  );

  assign outs = {state_o, cap1_en, cap2_en, cmp_en, busy, result_valid, match, error};

  always #5 clock = ~clock;

  // Cycle index: inputs driven at a negedge while cyc==N belong to cycle N;
  // their registered consequence is visible at the negedge where cyc==N+1.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [9:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  bit   model_match  = 1'b0;

  // Output vector a state must present, straight from the per-state rules.
  function automatic logic [9:0] pack(input seq_state_e s, input bit m);
    logic c1, c2, ce, bz, rv, er;
    c1 = (s == ST_CAP1);
    c2 = (s == ST_CAP2);
    ce = (s == ST_COMPARE);
    bz = (s == ST_CAP1) || (s == ST_CLR) || (s == ST_CAP2) || (s == ST_COMPARE);
    rv = (s == ST_DONE);
    er = (s == ST_ERROR);
    return {s, c1, c2, ce, bz, rv, m, er};
  endfunction

  function automatic void push_expect(input int at, input seq_state_e s);
    exp_t e;
    e.at  = at;
    e.val = pack(s, model_match);
    exp_q.push_back(e);
  endfunction

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic checkOutput(input string name, input int req_at, input logic [9:0] req_v,
                             input int act_at, input logic [9:0] act_v);
    tests_run++;
    if (req_at != act_at || req_v !== act_v) begin
      tests_failed++;
      $display("[TB] FAIL %s: got outputs %b at cycle %0d, required %b at cycle %0d",
               name, act_v, act_at, req_v, req_at);
    end
  endtask

  task automatic applyStimulus(input bit st, input bit ab, input bit tk, input bit s1,
                               input bit s2, input bit cv, input bit cm);
    @(negedge clock);
    start        = st;
    abort        = ab;
    sample_tick  = tk;
    stored1_done = s1;
    stored2_done = s2;
    cmp_valid    = cv;
    cmp_match    = cm;
  endtask

  // Monitor: every change of the output vector must match the oldest entry.
  logic [9:0] prev_outs = 10'b0;
  always @(negedge clock) begin
    if (outs !== prev_outs) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_change: got outputs %b at cycle %0d, required no change from %b",
                 outs, cyc, prev_outs);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("transition", e.at, e.val, cyc, outs);
      end
      prev_outs = outs;
    end
  end

  task automatic start_run();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    model_match = 1'b0;
    push_expect(cyc + 1, ST_CAP1);
  endtask

  // One capture phase; n_done < 0 means the bank never reports full.
  task automatic capture_phase(input int bank, input int n_done, output bit timed_out);
    int ticks = 0;
    int guard = 0;
    bit tk, done;
    timed_out = 1'b0;
    forever begin
      tk   = ($urandom_range(0, 3) != 0);
      done = 1'b0;
      if (tk) ticks++;
      if (n_done >= 0 && ticks >= n_done) done = 1'b1;
      if (bank == 1) applyStimulus(0, 0, tk, done, rbit(), rbit(), rbit());
      else           applyStimulus(0, 0, tk, rbit(), done, rbit(), rbit());
      if (done) begin
        if (bank == 1) begin
          push_expect(cyc + 1, ST_CLR);
          push_expect(cyc + 2, ST_CAP2);
        end else begin
          push_expect(cyc + 1, ST_COMPARE);
        end
        break;
      end
      if (ticks == CAP_LIMIT) begin
        push_expect(cyc + 1, ST_ERROR);
        timed_out = 1'b1;
        break;
      end
      guard++;
      if (guard > 2000) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL capture_guard: got %0d ticks, required %0d", ticks, CAP_LIMIT);
        break;
      end
    end
  endtask

  // Compare phase; wait_c < 0 means the comparator never answers.
  task automatic compare_phase(input int wait_c, input bit m);
    for (int c = 0; c < CT; c++) begin
      if (c == wait_c) begin
        applyStimulus(0, 0, rbit(), rbit(), rbit(), 1, m);
        model_match = m;
        push_expect(cyc + 1, ST_DONE);
        return;
      end
      applyStimulus(0, 0, rbit(), rbit(), rbit(), 0, rbit());
      if (c == CT - 1) push_expect(cyc + 1, ST_ERROR);
    end
  endtask

  task automatic reset_scenario();
    bit to;
    start_run();
    capture_phase(1, 2, to);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    capture_phase(2, 2, to);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    #1 reset_BTN = 1'b0;
    model_match = 1'b0;
    push_expect(cyc + 1, ST_IDLE);
    repeat (3) applyStimulus(1, rbit(), rbit(), rbit(), rbit(), rbit(), rbit());
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    reset_BTN = 1'b1;
    repeat (6) applyStimulus(1, 0, rbit(), rbit(), rbit(), rbit(), rbit());
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    start_run();
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    push_expect(cyc + 1, ST_IDLE);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

`ifndef SEQ_AUTO_REARM_EN
  task automatic full_run(input int n1, input int n2, input int cw, input bit m);
    bit to;
    start_run();
    capture_phase(1, n1, to);
    if (!to) begin
      applyStimulus(0, 0, rbit(), 1, 0, rbit(), rbit());
      capture_phase(2, n2, to);
      if (!to) compare_phase(cw, m);
    end
    repeat (3) applyStimulus(0, 0, rbit(), rbit(), rbit(), rbit(), rbit());
  endtask

  task automatic abort_scenario();
    bit to;
    start_run();
    capture_phase(1, 3, to);
    applyStimulus(0, 0, rbit(), 1, 0, 0, 0);
    repeat (4) applyStimulus(0, 0, rbit(), rbit(), 0, rbit(), rbit());
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 1, 1, 1);
    model_match = 1'b0;
    push_expect(cyc + 1, ST_IDLE);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask
`else
  task automatic rearm_round(input int n2, input int cw, input bit m);
    bit to;
    push_expect(cyc + 2, ST_CLR);
    push_expect(cyc + 3, ST_CAP2);
    applyStimulus(0, 0, rbit(), rbit(), rbit(), rbit(), rbit());
    applyStimulus(0, 0, rbit(), rbit(), rbit(), rbit(), rbit());
    capture_phase(2, n2, to);
    if (!to) compare_phase(cw, m);
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish by cycle %0d, required finish earlier", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit to;
    reset_BTN = 1'b0;
    start = 0; abort = 0; sample_tick = 0;
    stored1_done = 0; stored2_done = 0; cmp_valid = 0; cmp_match = 0;
    repeat (3) @(negedge clock);
    checkOutput("reset_state", cyc, 10'b0, cyc, outs);
    reset_BTN = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

`ifndef SEQ_AUTO_REARM_EN
    full_run(NS, NS, 100, 1'b1);
    for (int r = 0; r < 3; r++) begin
      full_run(int'($urandom_range(0, CAP_LIMIT - 1)), int'($urandom_range(0, CAP_LIMIT - 1)),
               int'($urandom_range(0, 300)), rbit());
    end
    full_run(CAP_LIMIT, CAP_LIMIT, CT - 1, 1'b1);
    full_run(0, 0, 0, 1'b0);
    full_run(-1, 0, 0, 1'b0);
    full_run(10, 10, 10, 1'b1);
    full_run(5, -1, 0, 1'b0);
    full_run(5, 5, -1, 1'b0);
    full_run(20, 20, 20, 1'b1);
    abort_scenario();
`else
    start_run();
    capture_phase(1, int'($urandom_range(0, CAP_LIMIT - 1)), to);
    applyStimulus(0, 0, rbit(), 1, 0, rbit(), rbit());
    capture_phase(2, int'($urandom_range(0, CAP_LIMIT - 1)), to);
    compare_phase(int'($urandom_range(0, 200)), 1'b1);
    rearm_round(int'($urandom_range(0, CAP_LIMIT - 1)), int'($urandom_range(0, 200)), 1'b0);
    rearm_round(int'($urandom_range(0, CAP_LIMIT - 1)), int'($urandom_range(0, 200)), 1'b1);
    push_expect(cyc + 2, ST_CLR);
    push_expect(cyc + 3, ST_CAP2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 1, 1);
    applyStimulus(0, 1, 1, 1, 1, 1, 1);
    model_match = 1'b0;
    push_expect(cyc + 1, ST_IDLE);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
`endif

    reset_scenario();

    repeat (5) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL missing_transition: got no change, required %b at cycle %0d", e.val, e.at);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
